// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: round-robin sharing of one up-counter among NREQ requesters.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   i_req         per-requester ownership request (level, held for the whole run)
//   i_en          per-requester count enable (only the owner's bit is used)
//   i_term        per-requester terminal value, slice i at [i*WIDTH +: WIDTH]
//   o_gnt         registered one-hot grant, high while the owner's run is active
//   o_busy        high while running or completing
//   o_owner       index of the current or last owner
//   o_count       shared counter value
//   o_done        one-hot, single-cycle completion pulse
module counter_share_arbiter #(
    parameter int NREQ = 4,
    parameter int WIDTH = 4,
    localparam int OW = $clog2(NREQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       i_req,
    input  logic [NREQ-1:0]       i_en,
    input  logic [NREQ*WIDTH-1:0] i_term,
    output logic [NREQ-1:0]       o_gnt,
    output logic                  o_busy,
    output logic [OW-1:0]         o_owner,
    output logic [WIDTH-1:0]      o_count,
    output logic [NREQ-1:0]       o_done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_state_n;
    logic [NREQ-1:0]  r_gnt, w_gnt_n, r_done, w_done_n;
    logic             r_busy, w_busy_n;
    logic [OW-1:0]    r_owner, w_owner_n, r_ptr, w_ptr_n, w_win, w_ptr_inc;
    logic [WIDTH-1:0] r_count, w_count_n, r_term_q, w_term_n;
    logic             w_found;
    int               w_idx;

    // First requesting index at or after the round-robin pointer.
    always_comb begin
        w_found = 1'b0;
        w_win = '0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NREQ;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_win = OW'(w_idx);
            end
        end
    end

    // Explicit wrap so non-power-of-two NREQ stays in range.
    assign w_ptr_inc = (r_owner == OW'(NREQ-1)) ? '0 : r_owner + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_gnt_n = r_gnt;
        w_done_n = '0;
        w_owner_n = r_owner;
        w_count_n = r_count;
        w_term_n = r_term_q;
        w_ptr_n = r_ptr;
        case (r_state)
            IDLE: begin
                w_gnt_n = '0;
                if (w_found) begin
                    w_state_n = RUN;
                    w_gnt_n = NREQ'(1) << w_win;
                    w_owner_n = w_win;
                    w_count_n = '0;
                    w_term_n = i_term[w_win*WIDTH +: WIDTH];
                end
            end
            RUN: begin
                // Terminal takes priority over a simultaneous request drop.
                if (i_en[r_owner] && r_count == r_term_q) begin
                    w_state_n = DONE;
                    w_done_n = NREQ'(1) << r_owner;
                    w_gnt_n = '0;
                end else if (!i_req[r_owner]) begin
                    w_state_n = IDLE;
                    w_gnt_n = '0;
                    w_ptr_n = w_ptr_inc;
                end else if (i_en[r_owner]) begin
                    w_count_n = r_count + 1'b1;
                end
            end
            DONE: begin
                w_state_n = IDLE;
                w_gnt_n = '0;
                w_ptr_n = w_ptr_inc;
            end
            default: begin
                w_state_n = IDLE;
                w_gnt_n = '0;
            end
        endcase
        w_busy_n = (w_state_n != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt <= '0;
            r_done <= '0;
            r_busy <= 1'b0;
            r_owner <= '0;
            r_count <= '0;
            r_term_q <= '0;
            r_ptr <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt <= w_gnt_n;
            r_done <= w_done_n;
            r_busy <= w_busy_n;
            r_owner <= w_owner_n;
            r_count <= w_count_n;
            r_term_q <= w_term_n;
            r_ptr <= w_ptr_n;
        end
    end

    assign o_gnt = r_gnt;
    assign o_done = r_done;
    assign o_busy = r_busy;
    assign o_owner = r_owner;
    assign o_count = r_count;
endmodule

// File: tb/tb_counter_share_arbiter.sv
// tb_counter_share_arbiter: directed self-checking bench for counter_share_arbiter.
module tb_counter_share_arbiter;
    localparam int NREQ = 4;
    localparam int WIDTH = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req, en;
    logic [NREQ*WIDTH-1:0] term;
    logic [NREQ-1:0]       gnt, done;
    logic                  busy;
    logic [1:0]            owner;
    logic [WIDTH-1:0]      count;
    int vectors = 0;
    int miscompares = 0;

    counter_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .i_req(req), .i_en(en), .i_term(term),
        .o_gnt(gnt), .o_busy(busy), .o_owner(owner), .o_count(count), .o_done(done)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        en = '0;
        term = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({gnt, busy, owner, count, done} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset gnt=%b busy=%b owner=%0d count=%0d done=%b want all 0", gnt, busy, owner, count, done);
        end
    endtask

    task automatic test_single();
        logic [WIDTH-1:0] exp_cnt;
        do_reset();
        term[1*WIDTH +: WIDTH] = 4'd3;
        en = 4'b0010;
        req = 4'b0010;
        step();
        vectors++;
        if (gnt !== 4'b0010 || busy !== 1'b1 || owner !== 2'd1 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL single_grant gnt=%b busy=%b owner=%0d count=%0d want 0010 1 1 0", gnt, busy, owner, count);
        end
        term[1*WIDTH +: WIDTH] = 4'd9;
        for (int i = 1; i <= 3; i++) begin
            step();
            exp_cnt = WIDTH'(i);
            vectors++;
            if (count !== exp_cnt || gnt !== 4'b0010 || done !== 4'b0000) begin
                miscompares++;
                $display("FAIL single_count%0d count=%0d gnt=%b done=%b want %0d 0010 0000", i, count, gnt, done, exp_cnt);
            end
        end
        step();
        vectors++;
        if (done !== 4'b0010 || gnt !== 4'b0000 || count !== 4'd3 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done done=%b gnt=%b count=%0d busy=%b want 0010 0000 3 1", done, gnt, count, busy);
        end
        req = '0;
        step();
        vectors++;
        if (done !== 4'b0000 || busy !== 1'b0 || owner !== 2'd1 || count !== 4'd3) begin
            miscompares++;
            $display("FAIL single_idle done=%b busy=%b owner=%0d count=%0d want 0000 0 1 3", done, busy, owner, count);
        end
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        do_reset();
        req = 4'b1111;
        en = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = NREQ'(1) << (i % NREQ);
            step();
            vectors++;
            if (gnt !== exp_g || done !== 4'b0000) begin
                miscompares++;
                $display("FAIL rr_grant%0d gnt=%b done=%b want %b 0000", i, gnt, done, exp_g);
            end
            step();
            vectors++;
            if (done !== exp_g || gnt !== 4'b0000) begin
                miscompares++;
                $display("FAIL rr_done%0d done=%b gnt=%b want %b 0000", i, done, gnt, exp_g);
            end
            step();
            vectors++;
            if (gnt !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_idle%0d gnt=%b done=%b busy=%b want 0000 0000 0", i, gnt, done, busy);
            end
        end
        req = '0;
        en = '0;
    endtask

    task automatic test_gated();
        logic [4:0] en_seq = 5'b10101;
        logic [WIDTH-1:0] exp_cnt [5] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2};
        logic [NREQ-1:0] exp_done;
        do_reset();
        term[2*WIDTH +: WIDTH] = 4'd2;
        req = 4'b0100;
        en = 4'b0001;
        step();
        vectors++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL gated_grant gnt=%b owner=%0d count=%0d want 0100 2 0", gnt, owner, count);
        end
        for (int i = 0; i < 5; i++) begin
            en = {1'b0, en_seq[i], 2'b01};
            step();
            exp_done = (i == 4) ? 4'b0100 : 4'b0000;
            vectors++;
            if (count !== exp_cnt[i] || done !== exp_done) begin
                miscompares++;
                $display("FAIL gated_cyc%0d count=%0d done=%b want %0d %b", i, count, done, exp_cnt[i], exp_done);
            end
        end
        req = '0;
        en = '0;
        step();
    endtask

    task automatic test_abort();
        do_reset();
        term[0 +: WIDTH] = 4'd5;
        req = 4'b1001;
        en = 4'b0001;
        step();
        vectors++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            miscompares++;
            $display("FAIL abort_grant gnt=%b owner=%0d want 0001 0", gnt, owner);
        end
        step();
        req = 4'b1000;
        step();
        vectors++;
        if (gnt !== 4'b0000 || done !== 4'b0000 || count !== 4'd1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_stop gnt=%b done=%b count=%0d busy=%b want 0000 0000 1 0", gnt, done, count, busy);
        end
        step();
        vectors++;
        if (gnt !== 4'b1000 || owner !== 2'd3 || count !== 4'd0) begin
            miscompares++;
            $display("FAIL abort_next gnt=%b owner=%0d count=%0d want 1000 3 0", gnt, owner, count);
        end
        req = '0;
        en = '0;
        step();
    endtask

    task automatic test_tie();
        do_reset();
        term[1*WIDTH +: WIDTH] = 4'd1;
        req = 4'b0010;
        en = 4'b0010;
        step();
        step();
        req = 4'b0000;
        step();
        vectors++;
        if (done !== 4'b0010 || gnt !== 4'b0000 || busy !== 1'b1 || count !== 4'd1) begin
            miscompares++;
            $display("FAIL tie_done done=%b gnt=%b busy=%b count=%0d want 0010 0000 1 1", done, gnt, busy, count);
        end
        step();
        vectors++;
        if (done !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL tie_idle done=%b busy=%b gnt=%b want 0000 0 0000", done, busy, gnt);
        end
        en = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        term[0 +: WIDTH] = 4'd7;
        req = 4'b0001;
        en = 4'b0001;
        step();
        step();
        step();
        vectors++;
        if (count !== 4'd2 || gnt !== 4'b0001) begin
            miscompares++;
            $display("FAIL midrst_pre count=%0d gnt=%b want 2 0001", count, gnt);
        end
        reset = 1'b1;
        req = 4'b0110;
        step();
        reset = 1'b0;
        vectors++;
        if ({gnt, busy, owner, count, done} !== 15'd0) begin
            miscompares++;
            $display("FAIL midrst_zero gnt=%b busy=%b owner=%0d count=%0d done=%b want all 0", gnt, busy, owner, count, done);
        end
        step();
        vectors++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            miscompares++;
            $display("FAIL midrst_grant gnt=%b owner=%0d want 0010 1", gnt, owner);
        end
        req = '0;
        en = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_gated();
        test_abort();
        test_tie();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
